// File: rtl/reg_dump_reader_if.sv
// rtl/reg_dump_reader_if.sv - control, register-file read port and dump stream of reg_dump_reader
interface reg_dump_reader_if;
    logic        start;
    logic        abort;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;

    modport master (
        input  start, abort, rd_data, dump_ready,
        output rd_addr, dump_valid, dump_addr, dump_data, dump_last, busy, done
    );

    modport slave (
        output start, abort, rd_data, dump_ready,
        input  rd_addr, dump_valid, dump_addr, dump_data, dump_last, busy, done
    );
endinterface

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - streams register-file words START_REG..END_REG out, one word per READ/SEND pair
module reg_dump_reader #(
    parameter int unsigned START_REG = 0,
    parameter int unsigned END_REG   = 31
) (
    input  logic               clock,
    input  logic               rst,
    reg_dump_reader_if.master  bus
);
    localparam logic [4:0] START_IDX = 5'(START_REG);
    localparam logic [4:0] END_IDX   = 5'(END_REG);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    ptr_d   = START_IDX;
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    // Snapshot taken here: a same-edge register write is not seen.
                    data_d  = bus.rd_data;
                    addr_d  = ptr_q;
                    last_d  = (ptr_q == END_IDX);
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.dump_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= START_IDX;
            addr_q  <= 5'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign bus.rd_addr    = ptr_q;
    assign bus.dump_valid = valid_q;
    assign bus.dump_addr  = addr_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_last  = last_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - scoreboard bench for reg_dump_reader (full range and single-register instances)
module tb_reg_dump_reader;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } word_t;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [31:0] regs [32];
    word_t       sb0[$];
    word_t       sb1[$];
    int          checks    = 0;
    int          failures  = 0;
    int          done_cnt0 = 0;
    int          done_cnt1 = 0;
    bit          rnd_mode  = 1'b0;
    bit          wrote3    = 1'b0;

    reg_dump_reader_if if0 ();
    reg_dump_reader_if if1 ();

    reg_dump_reader #(.START_REG(0), .END_REG(31)) u_full (.clock(clock), .rst(rst), .bus(if0));
    reg_dump_reader #(.START_REG(7), .END_REG(7))  u_one  (.clock(clock), .rst(rst), .bus(if1));

    always #5 clock = ~clock;

    assign if0.rd_data = regs[if0.rd_addr];
    assign if1.rd_data = regs[if1.rd_addr];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] expv(input int i);
        if (i == 3 && wrote3) return 32'hDEADBEEF;
        return 32'(i) * 32'h11111111;
    endfunction

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            sb0.push_back({5'(i), expv(i), (i == 31)});
    endtask

    // ready changes just after the rising edge so the negedge monitor sees what the DUT sees
    initial begin
        if0.dump_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1 if0.dump_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : mon0
        word_t w;
        logic [37:0] prev;
        bit hold = 1'b0;
        forever begin
            @(negedge clock);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    check("m0_hold", {if0.dump_valid, if0.dump_addr, if0.dump_data, if0.dump_last}, {1'b1, prev});
                if (if0.dump_valid && if0.dump_ready) begin
                    if (sb0.size() == 0) begin
                        check("m0_extra_word", {if0.dump_addr, if0.dump_data}, 0);
                    end else begin
                        w = sb0.pop_front();
                        check("m0_word", {if0.dump_addr, if0.dump_data, if0.dump_last}, w);
                    end
                end
                hold = if0.dump_valid && !if0.dump_ready && !if0.abort;
                prev = {if0.dump_addr, if0.dump_data, if0.dump_last};
                if (if0.done) done_cnt0++;
            end
        end
    end

    initial begin : mon1
        word_t w;
        forever begin
            @(negedge clock);
            if (!rst) begin
                if (if1.dump_valid && if1.dump_ready) begin
                    if (sb1.size() == 0) begin
                        check("m1_extra_word", {if1.dump_addr, if1.dump_data}, 0);
                    end else begin
                        w = sb1.pop_front();
                        check("m1_word", {if1.dump_addr, if1.dump_data, if1.dump_last}, w);
                    end
                end
                if (if1.done) done_cnt1++;
            end
        end
    end

    task automatic start_pulse();
        if0.start = 1'b1;
        @(negedge clock);
        if0.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!if0.done && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        if (!if0.done) check("done_timeout", 0, 1);
    endtask

    task automatic wait_word(input logic [4:0] a);
        int n = 0;
        while (!(if0.dump_valid && if0.dump_addr == a) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) check("word_timeout", 0, 1);
    endtask

    initial begin : stim
        int cyc;
        int n;
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] <= 32'(i) * 32'h11111111;
        repeat (3) @(negedge clock);
        check("rst_outs0", {if0.rd_addr, if0.dump_valid, if0.dump_addr, if0.dump_data,
                            if0.dump_last, if0.busy, if0.done}, 0);
        check("rst_rd_addr1", if1.rd_addr, 7);
        check("rst_busy1", {if1.busy, if1.dump_valid, if1.done}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clock);

        // full dump, ready held high: 64 cycles, one done
        push_range(0, 31);
        start_pulse();
        wait_done(cyc);
        check("full_cycles", cyc, 64);
        @(negedge clock);
        check("done_one_cycle", if0.done, 0);
        check("full_done_cnt", done_cnt0, 1);
        check("full_sb_empty", sb0.size(), 0);

        // random backpressure plus a start while busy
        rnd_mode = 1'b1;
        push_range(0, 31);
        start_pulse();
        repeat (20) @(negedge clock);
        start_pulse();
        wait_done(cyc);
        rnd_mode = 1'b0;
        repeat (3) @(negedge clock);
        check("rnd_done_cnt", done_cnt0, 2);
        check("rnd_sb_empty", sb0.size(), 0);

        // abort coinciding with the handshake of addr 5
        push_range(0, 5);
        start_pulse();
        wait_word(5'd5);
        #2 if0.abort = 1'b1;
        @(posedge clock);
        #1 check("abort_outs", {if0.busy, if0.dump_valid, if0.dump_last, if0.done}, 0);
        @(negedge clock);
        if0.abort = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_no_done", done_cnt0, 2);
        check("abort_sb_empty", sb0.size(), 0);
        push_range(0, 31);
        start_pulse();
        wait_done(cyc);
        check("restart_cycles", cyc, 64);

        // same-edge write to reg 3 is not captured; next dump starts in the done cycle
        push_range(0, 31);
        start_pulse();
        n = 0;
        while (!(if0.busy && !if0.dump_valid && if0.rd_addr == 5'd3) && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        regs[3] <= 32'hDEADBEEF;
        wrote3 = 1'b1;
        wait_done(cyc);
        push_range(0, 31);
        start_pulse();
        wait_done(cyc);
        check("snap_cycles", cyc, 64);
        repeat (2) @(negedge clock);
        check("snap_done_cnt", done_cnt0, 5);
        check("snap_sb_empty", sb0.size(), 0);

        // reset during SEND of addr 10
        push_range(0, 10);
        start_pulse();
        wait_word(5'd10);
        #2 rst = 1'b1;
        #1 check("rst_mid_outs", {if0.rd_addr, if0.dump_valid, if0.dump_addr, if0.dump_data,
                                  if0.dump_last, if0.busy, if0.done}, 0);
        check("rst_mid_sb_empty", sb0.size(), 0);
        @(negedge clock);
        rst = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_needs_start", {if0.busy, if0.dump_valid}, 0);
        check("rst_no_done", done_cnt0, 5);

        // single-register instance
        sb1.push_back({5'd7, 32'h77777777, 1'b1});
        if1.start = 1'b1;
        @(negedge clock);
        if1.start = 1'b0;
        repeat (4) @(negedge clock);
        check("one_done_cnt", done_cnt1, 1);
        check("one_sb_empty", sb1.size(), 0);
        check("one_idle", if1.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
